// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Purpose  : MM:SS BCD countdown core with alarm, driven by a 1 Hz tick strobe.
//            Optional blink output enabled with `define COUNTDOWN_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int ALARM_TICKS  = 10,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] preset_bcd,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic [1:0]  state,
    output logic        running,
    output logic        alarm,
`ifdef COUNTDOWN_BLINK_EN
    output logic        done_pulse,
    output logic        blank
`else
    output logic        done_pulse
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam int                 c_CNT_W  = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(ALARM_TICKS - 1);
    localparam logic [3:0]         c_MAX_MT = MAX_MIN_TENS[3:0];

    state_t               r_state;
    logic [15:0]          r_time;
    logic [c_CNT_W-1:0]   r_alarm_cnt;
    logic                 r_running;
    logic                 r_alarm;
    logic                 r_done_pulse;
    logic [15:0]          w_preset;
    logic [15:0]          w_dec;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Clamp to 9 first, then to the per-position limit.
    function automatic logic [15:0] sanitise(input logic [15:0] p);
        logic [15:0] s;
        s[15:12] = clamp(clamp(p[15:12], 4'd9), c_MAX_MT);
        s[11:8]  = clamp(p[11:8], 4'd9);
        s[7:4]   = clamp(clamp(p[7:4], 4'd9), 4'd5);
        s[3:0]   = clamp(p[3:0], 4'd9);
        return s;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] d;
        d = t;
        if (t[3:0] != 4'd0) begin
            d[3:0] = t[3:0] - 4'd1;
        end else begin
            d[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                d[7:4] = t[7:4] - 4'd1;
            end else begin
                d[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    d[11:8] = t[11:8] - 4'd1;
                end else begin
                    d[11:8]  = 4'd9;
                    d[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return d;
    endfunction

    assign w_preset = sanitise(preset_bcd);
    assign w_dec    = bcd_dec(r_time);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_time       <= 16'h0000;
            r_alarm_cnt  <= '0;
            r_running    <= 1'b0;
            r_alarm      <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (clear) begin
                r_state     <= S_IDLE;
                r_time      <= 16'h0000;
                r_alarm_cnt <= '0;
                r_running   <= 1'b0;
                r_alarm     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (load) begin
                            r_time <= w_preset;
                        end else if (start && (r_time != 16'h0000)) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (load) begin
                            r_state   <= S_IDLE;
                            r_time    <= w_preset;
                            r_running <= 1'b0;
                        end else if (stop) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (tick) begin
                            r_time <= w_dec;
                            if (w_dec == 16'h0000) begin
                                r_state      <= S_DONE;
                                r_running    <= 1'b0;
                                r_alarm      <= 1'b1;
                                r_done_pulse <= 1'b1;
                                r_alarm_cnt  <= '0;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (load) begin
                            r_state <= S_IDLE;
                            r_time  <= w_preset;
                        end else if (!stop && start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (load || stop || start) begin
                            r_state     <= S_IDLE;
                            r_alarm     <= 1'b0;
                            r_alarm_cnt <= '0;
                            if (load) begin
                                r_time <= w_preset;
                            end
                        end else if (tick) begin
                            if (r_alarm_cnt == c_LAST) begin
                                r_state     <= S_IDLE;
                                r_alarm     <= 1'b0;
                                r_alarm_cnt <= '0;
                            end else begin
                                r_alarm_cnt <= r_alarm_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    logic r_blank;
    logic w_pause_hold;
    logic w_done_hold;

    // High only when the FSM stays in PAUSE/DONE this cycle; any exit clears blank.
    assign w_pause_hold = (r_state == S_PAUSE) && !clear && !load && !(start && !stop);
    assign w_done_hold  = (r_state == S_DONE) && !clear && !load && !start && !stop
                          && !(tick && (r_alarm_cnt == c_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blank <= 1'b0;
        end else if (w_pause_hold || w_done_hold) begin
            if (tick) begin
                r_blank <= ~r_blank;
            end
        end else begin
            r_blank <= 1'b0;
        end
    end

    assign blank = r_blank;
`endif

    assign time_bcd   = r_time;
    assign state      = r_state;
    assign running    = r_running;
    assign alarm      = r_alarm;
    assign done_pulse = r_done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Directed, table-driven self-checking bench for countdown_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_DONE  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick, load, start, stop, clear;
    logic [15:0] preset_bcd;
    logic [15:0] time_bcd;
    logic [1:0]  state;
    logic        running, alarm, done_pulse;
`ifdef COUNTDOWN_BLINK_EN
    logic        blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        tick, load;
        logic [15:0] preset;
        logic        start, stop, clear;
        logic [15:0] e_time;
        logic [1:0]  e_state;
        logic        e_run, e_alarm, e_done;
    } vec_t;

    vec_t vq[$];

    countdown_timer #(.ALARM_TICKS(10), .MAX_MIN_TENS(5)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .tick       (tick),
        .load       (load),
        .preset_bcd (preset_bcd),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .time_bcd   (time_bcd),
        .state      (state),
        .running    (running),
        .alarm      (alarm),
`ifdef COUNTDOWN_BLINK_EN
        .done_pulse (done_pulse),
        .blank      (blank)
`else
        .done_pulse (done_pulse)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic t, input logic l, input logic [15:0] p,
                                input logic s, input logic sp, input logic c,
                                input logic [15:0] et, input logic [1:0] es,
                                input logic er, input logic ea, input logic ed);
        vec_t v;
        v.tick = t; v.load = l; v.preset = p; v.start = s; v.stop = sp; v.clear = c;
        v.e_time = et; v.e_state = es; v.e_run = er; v.e_alarm = ea; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] et, input logic [1:0] es,
                             input logic er, input logic ea, input logic ed);
        chk({tag, ".time"},    time_bcd,            et);
        chk({tag, ".state"},   {14'd0, state},      {14'd0, es});
        chk({tag, ".running"}, {15'd0, running},    {15'd0, er});
        chk({tag, ".alarm"},   {15'd0, alarm},      {15'd0, ea});
        chk({tag, ".done"},    {15'd0, done_pulse}, {15'd0, ed});
    endtask

    task automatic drive(input logic t, input logic l, input logic [15:0] p,
                         input logic s, input logic sp, input logic c);
        @(negedge clk);
        tick = t; load = l; preset_bcd = p; start = s; stop = sp; clear = c;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        preset_bcd = 16'h0000;
        #12;
        check_all("reset", 16'h0000, c_IDLE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table: tick, load, preset, start, stop, clear | time, state, run, alarm, done
        vq.push_back(mk(0,1,16'h0103,0,0,0, 16'h0103, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0103, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0102, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0101, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0100, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0059, c_RUN,   1,0,0));
        vq.push_back(mk(0,1,16'h0002,0,0,0, 16'h0002, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0002, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0001, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000, c_DONE,  0,1,1));
        vq.push_back(mk(0,0,16'h0000,0,0,0, 16'h0000, c_DONE,  0,1,0));
        for (int i = 0; i < 9; i++)
            vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000, c_DONE, 0,1,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,1,16'hFA7C,0,0,0, 16'h5959, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,1,16'h0130,0,0,0, 16'h0130, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0130, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,1,0, 16'h0130, c_PAUSE, 0,0,0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0130, c_PAUSE, 0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0130, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0129, c_RUN,   1,0,0));
        vq.push_back(mk(1,1,16'h0045,0,0,0, 16'h0045, c_IDLE,  0,0,0));
        vq.push_back(mk(1,0,16'h0000,1,0,0, 16'h0045, c_RUN,   1,0,0));
        vq.push_back(mk(1,1,16'h1000,0,0,0, 16'h1000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h1000, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0959, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,1,0,0, 16'h0958, c_RUN,   1,0,0));
        vq.push_back(mk(0,1,16'h9A6B,0,1,0, 16'h5959, c_IDLE,  0,0,0));
        vq.push_back(mk(0,1,16'h0001,0,0,0, 16'h0001, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0001, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000, c_DONE,  0,1,1));
        vq.push_back(mk(0,0,16'h0000,0,1,0, 16'h0000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,1,16'h0001,0,0,0, 16'h0001, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0001, c_RUN,   1,0,0));
        vq.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000, c_DONE,  0,1,1));
        vq.push_back(mk(0,0,16'h0000,1,0,0, 16'h0000, c_IDLE,  0,0,0));
        vq.push_back(mk(0,1,16'h0003,0,0,0, 16'h0003, c_IDLE,  0,0,0));
        vq.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000, c_IDLE,  0,0,0));

        foreach (vq[i]) begin
            drive(vq[i].tick, vq[i].load, vq[i].preset, vq[i].start, vq[i].stop, vq[i].clear);
            check_all($sformatf("vec%0d", i), vq[i].e_time, vq[i].e_state,
                      vq[i].e_run, vq[i].e_alarm, vq[i].e_done);
        end

        // Asynchronous reset in the middle of a clock period while running.
        drive(0,1,16'h0045,0,0,0);
        drive(0,0,16'h0000,1,0,0);
        check_all("pre_reset", 16'h0045, c_RUN, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, c_IDLE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef COUNTDOWN_BLINK_EN
        begin
            logic [3:0] exp_blank;
            exp_blank = 4'b0101;
            drive(0,1,16'h0010,0,0,0);
            drive(0,0,16'h0000,1,0,0);
            drive(0,0,16'h0000,0,1,0);
            chk("blank_pause_entry", {15'd0, blank}, 16'd0);
            for (int i = 0; i < 4; i++) begin
                drive(1,0,16'h0000,0,0,0);
                chk($sformatf("blank_tick%0d", i), {15'd0, blank}, {15'd0, exp_blank[i]});
            end
            drive(1,0,16'h0000,0,0,0);
            chk("blank_tick4", {15'd0, blank}, 16'd1);
            drive(0,0,16'h0000,1,0,0);
            chk("blank_start", {15'd0, blank}, 16'd0);
            chk("blank_run_state", {14'd0, state}, {14'd0, c_RUN});
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- MM:SS BCD countdown core for the kitchen timer; the down-counting counterpart of the elapsed-time count-up block.
- The user loads a preset, starts, pauses or clears it. It decrements once per external 1 Hz tick and raises an alarm when it reaches 00:00.
- Sits between the button debouncers / clock divider and the 7-segment display mux, which consumes time_bcd.

Parameters:
- ALARM_TICKS, 10: number of ticks the alarm stays asserted in DONE before auto-return to IDLE (min 1).
- MAX_MIN_TENS, 5: maximum value of the minutes-tens digit; largest preset is MAX_MIN_TENS9:59.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick  input  1  one-clk-wide enable strobe, 1 Hz, from the clock divider
- load  input  1  one-cycle pulse: capture preset_bcd
- preset_bcd  input  16  {min_tens, min_ones, sec_tens, sec_ones}, 4-bit BCD each
- start  input  1  one-cycle pulse: run / resume / acknowledge
- stop  input  1  one-cycle pulse: pause / acknowledge
- clear  input  1  one-cycle pulse: zero and go IDLE
- time_bcd  output  16  current remaining time, same digit order as preset_bcd
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- running  output  1  high in RUN
- alarm  output  1  high in DONE
- done_pulse  output  1  one clk high on entry to DONE

Behaviour:
- Reset (reset=0, async): time_bcd=0000, state=IDLE, running=0, alarm=0, done_pulse=0, alarm counter=0.
- All outputs are registered and update on the clk edge where the input is sampled (1-cycle latency).
- Input priority within a cycle: clear > load > stop > start > tick.
- Preset sanitising on load, per digit:
  - any digit >9 is forced to 9
  - sec_tens >5 is forced to 5
  - min_tens >MAX_MIN_TENS is forced to MAX_MIN_TENS
- clear, any state: time_bcd=0000, IDLE, alarm=0, alarm counter=0.
- IDLE:
  - load: capture sanitised preset, stay IDLE.
  - start with time_bcd != 0000: go RUN.
  - start with time_bcd = 0000: ignored.
  - tick: ignored.
- RUN:
  - tick: BCD decrement of time_bcd.
    - sec_ones 0 wraps to 9 with borrow.
    - sec_tens 0 wraps to 5 with borrow.
    - min_ones 0 wraps to 9 with borrow.
    - min_tens decrements; it is never 0 while borrowing, because 0000 never remains in RUN.
  - If the decremented value is 0000: go DONE that same edge, alarm=1, done_pulse=1 for one cycle, alarm counter=0.
  - stop: go PAUSE, no decrement even if tick is coincident.
  - load: go IDLE with the new preset (abort).
  - start: ignored.
- PAUSE:
  - time frozen, tick ignored.
  - start: go RUN; the next tick decrements.
  - load: IDLE with the new preset.
  - stop: ignored.
- DONE:
  - time_bcd holds 0000, alarm=1.
  - Each tick increments the alarm counter. The tick that brings the count to ALARM_TICKS returns to IDLE and drops alarm.
  - start or stop: acknowledge, immediately IDLE, alarm=0.
  - load: IDLE with the new preset, alarm=0.
- A tick and a load in the same cycle: load wins, no decrement.
- Reset asserted mid-RUN or mid-DONE: all state lost, outputs return to reset values asynchronously.

Optional Feature:
- Macro COUNTDOWN_BLINK_EN.
- When defined:
  - Extra output port blank (1 bit). It toggles on every tick while in PAUSE or DONE, and is 0 in IDLE and RUN.
  - blank is cleared on any state transition and by reset.
  - The display mux blanks the digits when blank=1.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset then load 16'h0103, start, 3 ticks -> time_bcd 0102, 0101, 0100. Next tick -> 0059 (borrow through sec_tens to 5).
- Load 16'h0002, start, 2 ticks -> 0001 then 0000 with state=DONE, alarm=1, done_pulse high exactly one cycle. ALARM_TICKS=10 further ticks -> IDLE, alarm=0 after the 10th.
- Load 16'hFA7C -> captured value is 5959. Start at 0000 (after clear) -> state stays IDLE.
- RUN from 0130, assert stop and tick in the same cycle -> PAUSE with 0130. 5 ticks -> unchanged. Start, tick -> 0129.
- In DONE, pulse stop -> IDLE next edge, alarm=0. Separately: in RUN at 0045, drive reset low between edges -> time_bcd=0000, state=IDLE immediately, without a clk edge.
- With COUNTDOWN_BLINK_EN: in PAUSE, 4 ticks -> blank sequence 1,0,1,0. Start -> blank=0.
